// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the IFU (read-only) and the LSU
// (read/write). Round-robin arbitration on ties, a programmable wait before
// each access to model memory latency, and a held response until the owner
// takes it. A single transaction is in flight at any time.
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int LW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LW-1:0]     lat_cfg,
  // IFU request / response
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [AW-1:0]     ifu_addr,
  output logic              ifu_rsp_valid,
  input  logic              ifu_rsp_ready,
  output logic [DW-1:0]     ifu_rdata,
  // LSU request / response
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic              lsu_wen,
  input  logic [AW-1:0]     lsu_addr,
  input  logic [DW-1:0]     lsu_wdata,
  input  logic [DW/8-1:0]   lsu_wmask,
  output logic              lsu_rsp_valid,
  input  logic              lsu_rsp_ready,
  output logic [DW-1:0]     lsu_rdata,
  // Shared memory port
  output logic              mem_en,
  output logic              mem_wen,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  output logic [DW/8-1:0]   mem_wmask,
  input  logic [DW-1:0]     mem_rdata
);

  localparam int MW = DW / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Port encoding used by owner_q / last_grant_q
  localparam logic PORT_IFU = 1'b0;
  localparam logic PORT_LSU = 1'b1;

  state_e          state_q,      state_d;
  logic [LW-1:0]   cnt_q,        cnt_d;
  logic            last_grant_q, last_grant_d;
  logic            owner_q,      owner_d;
  logic            wen_q,        wen_d;
  logic [AW-1:0]   addr_q,       addr_d;
  logic [DW-1:0]   wdata_q,      wdata_d;
  logic [MW-1:0]   wmask_q,      wmask_d;
  logic [DW-1:0]   rdata_q,      rdata_d;
  // Set for the single IDLE cycle that follows a response handshake; no
  // request is accepted in that cycle, which gives one transaction every
  // lat_cfg+4 cycles under continuous load.
  logic            hold_q,       hold_d;

  logic            grant_ifu;
  logic            grant_lsu;
  logic            can_accept;
  logic            accept;
  logic            mem_fire;
  logic            rsp_hs;

  // Arbitration, request handshake and access/response qualifiers
  always_comb begin
    grant_lsu  = lsu_req_valid && (!ifu_req_valid || (last_grant_q == PORT_IFU));
    grant_ifu  = ifu_req_valid && !grant_lsu;
    // Readys are forced low while reset is held so every output reads 0.
    can_accept = (state_q == S_IDLE) && !hold_q && !rst;
    ifu_req_ready = can_accept && grant_ifu;
    lsu_req_ready = can_accept && grant_lsu;
    accept     = ifu_req_ready || lsu_req_ready;
    mem_fire   = (state_q == S_WAIT) && (cnt_q == '0);
    rsp_hs     = (state_q == S_RESP) &&
                 ((owner_q == PORT_LSU) ? lsu_rsp_ready : ifu_rsp_ready);
  end

  // Next-state logic for the FSM and the latched transaction fields
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    wen_d        = wen_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    rdata_d      = rdata_q;
    hold_d       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d      = S_WAIT;
          cnt_d        = lat_cfg;
          owner_d      = lsu_req_ready;
          last_grant_d = lsu_req_ready;
          if (lsu_req_ready) begin
            wen_d   = lsu_wen;
            addr_d  = lsu_addr;
            wdata_d = lsu_wdata;
            // Reads never drive byte enables onto the memory port.
            wmask_d = lsu_wen ? lsu_wmask : '0;
          end else begin
            wen_d   = 1'b0;
            addr_d  = ifu_addr;
            wdata_d = '0;
            wmask_d = '0;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - LW'(1);
        end else begin
          // mem_rdata is only valid in the access cycle, so capture it here.
          state_d = S_RESP;
          rdata_d = wen_q ? '0 : mem_rdata;
        end
      end
      S_RESP: begin
        if (rsp_hs) begin
          state_d = S_IDLE;
          hold_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and transaction registers; reset drops any in-flight transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_grant_q <= PORT_IFU;
      owner_q      <= PORT_IFU;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      rdata_q      <= '0;
      hold_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      wen_q        <= wen_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      rdata_q      <= rdata_d;
      hold_q       <= hold_d;
    end
  end

  // Memory port and response outputs; everything idles at 0
  always_comb begin
    mem_en    = mem_fire;
    mem_wen   = mem_fire && wen_q;
    mem_addr  = mem_fire ? addr_q  : '0;
    mem_wdata = mem_fire ? wdata_q : '0;
    mem_wmask = mem_fire ? wmask_q : '0;

    ifu_rsp_valid = (state_q == S_RESP) && (owner_q == PORT_IFU);
    lsu_rsp_valid = (state_q == S_RESP) && (owner_q == PORT_LSU);
    ifu_rdata     = ifu_rsp_valid ? rdata_q : '0;
    lsu_rdata     = lsu_rsp_valid ? rdata_q : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes the expected transaction
// (grant port, memory fields, response data, latency, accept spacing) and a
// negedge monitor pops and checks as the DUT accepts, accesses and responds.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  lat_cfg;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_ready;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_en, mem_wen;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  always #5 clk = ~clk;

  // Memory model: data valid only in the access cycle, garbage otherwise.
  assign mem_rdata = mem_en ? {16'h0000, mem_addr[15:0] ^ 16'h0413} : 32'hBAD0_BAD0;

  mem_arbiter #(.AW(32), .DW(32), .LW(5)) dut (
    .clk(clk), .rst(rst), .lat_cfg(lat_cfg),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rdata(lsu_rdata),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
  );

  typedef struct {
    bit          port;   // 0 = IFU, 1 = LSU
    logic        mwen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] rdata;
    int          lat;
    int          gap;    // cycles since previous accept / reset release, -1 = unchecked
  } exp_t;

  exp_t expq[$];
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: event occurred, expected none (cycle %0d)", name, cyc);
  endtask

  task automatic push(input bit port, input logic mwen, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] wmask,
                      input logic [31:0] rdata, input int lat, input int gap);
    exp_t e;
    e.port = port; e.mwen = mwen; e.addr = addr; e.wdata = wdata; e.wmask = wmask;
    e.rdata = rdata; e.lat = lat; e.gap = gap;
    expq.push_back(e);
  endtask

  // ---------------- monitor ----------------
  exp_t        cur;
  bit          in_flight = 0;
  bit          mem_seen = 0;
  bit          rsp_seen = 0;
  int          acc_cyc = 0;
  int          last_acc = 0;
  logic [31:0] own_rd, oth_rd;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ctl_zero", {ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid,
                           mem_en, mem_wen, mem_wmask}, 64'h0);
      chk("rst_data_zero", {mem_addr | mem_wdata, ifu_rdata | lsu_rdata}, 64'h0);
      in_flight = 0;
      last_acc  = cyc + 1;
    end else begin
      chk("ready_excl", ifu_req_ready & lsu_req_ready, 64'h0);
      if ((ifu_req_ready && ifu_req_valid) || (lsu_req_ready && lsu_req_valid)) begin
        acc_cnt++;
        if (in_flight) flag("accept_while_busy");
        if (expq.size() == 0) begin
          flag("unexpected_accept");
        end else begin
          cur = expq.pop_front();
          chk("grant_port", lsu_req_ready, cur.port);
          if (cur.gap >= 0) chk("accept_gap", cyc - last_acc, cur.gap);
        end
        in_flight = 1; mem_seen = 0; rsp_seen = 0;
        acc_cyc = cyc; last_acc = cyc;
      end
      if (mem_en) begin
        if (!in_flight || mem_seen) begin
          flag("extra_mem_en");
        end else begin
          chk("mem_cycle", cyc - acc_cyc, cur.lat + 1);
          chk("mem_wen", mem_wen, cur.mwen);
          chk("mem_addr", mem_addr, cur.addr);
          chk("mem_wmask", mem_wmask, cur.wmask);
          if (cur.mwen) chk("mem_wdata", mem_wdata, cur.wdata);
          mem_seen = 1;
        end
      end else begin
        chk("mem_idle_data", {mem_addr, mem_wdata}, 64'h0);
        chk("mem_idle_ctl", {mem_wen, mem_wmask}, 64'h0);
      end
      if (ifu_rsp_valid || lsu_rsp_valid) begin
        if (!in_flight || !mem_seen) begin
          flag("rsp_without_access");
        end else begin
          own_rd = cur.port ? lsu_rdata : ifu_rdata;
          oth_rd = cur.port ? ifu_rdata : lsu_rdata;
          chk("rsp_port", {ifu_rsp_valid, lsu_rsp_valid}, cur.port ? 2'b01 : 2'b10);
          chk("other_rdata", oth_rd, 64'h0);
          if (!rsp_seen) begin
            chk("rsp_cycle", cyc - acc_cyc, cur.lat + 2);
            chk("rsp_rdata", own_rd, cur.rdata);
            rsp_seen = 1;
          end else begin
            chk("rsp_stable", own_rd, cur.rdata);
          end
          if (cur.port ? lsu_rsp_ready : ifu_rsp_ready) begin
            in_flight = 0;
            done_cnt++;
          end
        end
      end else if (in_flight && rsp_seen) begin
        flag("rsp_dropped");
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_acc1();
    int t = acc_cnt + 1;
    int n = 0;
    while (acc_cnt < t && n < 300) begin @(posedge clk); n++; end
    if (acc_cnt < t) $display("FAIL accept_timeout: got %0d accepts, expected %0d", acc_cnt, t);
    if (acc_cnt < t) begin compared++; mismatched++; end
  endtask

  task automatic wait_done_n(input int k);
    int t = done_cnt + k;
    int n = 0;
    while (done_cnt < t && n < 500) begin @(posedge clk); n++; end
    if (done_cnt < t) $display("FAIL done_timeout: got %0d responses, expected %0d", done_cnt, t);
    if (done_cnt < t) begin compared++; mismatched++; end
  endtask

  initial begin
    int n;
    rst = 1'b1; lat_cfg = 5'd0;
    ifu_req_valid = 0; ifu_addr = '0; ifu_rsp_ready = 1;
    lsu_req_valid = 0; lsu_wen = 0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
    lsu_rsp_ready = 1;

    // IFU read held valid through reset, accepted in the first IDLE cycle
    lat_cfg = 5'd3; ifu_addr = 32'h8000_0000; ifu_req_valid = 1;
    push(0, 0, 32'h8000_0000, 32'h0, 4'h0, 32'h0000_0413, 3, 0);
    repeat (3) @(posedge clk);
    #1 rst = 0;
    wait_acc1(); #1 ifu_req_valid = 0;
    wait_done_n(1);

    // LSU write, lat 0
    #1 lat_cfg = 5'd0; lsu_wen = 1; lsu_addr = 32'h8000_0100;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'h3; lsu_req_valid = 1;
    push(1, 1, 32'h8000_0100, 32'hDEAD_BEEF, 4'h3, 32'h0, 0, -1);
    wait_acc1(); #1 lsu_req_valid = 0;
    wait_done_n(1);

    // LSU read: byte mask must not reach the memory port
    #1 lat_cfg = 5'd2; lsu_wen = 0; lsu_addr = 32'h8000_0024;
    lsu_wdata = 32'h1111_2222; lsu_wmask = 4'hF; lsu_req_valid = 1;
    push(1, 0, 32'h8000_0024, 32'h0, 4'h0, 32'h0000_0437, 2, -1);
    wait_acc1(); #1 lsu_req_valid = 0;
    wait_done_n(1);

    // lat_cfg changed right after accept is ignored
    #1 lat_cfg = 5'd2; ifu_addr = 32'h8000_0060; ifu_req_valid = 1;
    push(0, 0, 32'h8000_0060, 32'h0, 4'h0, 32'h0000_0473, 2, -1);
    wait_acc1(); #1 ifu_req_valid = 0; lat_cfg = 5'd20;
    wait_done_n(1);

    // Response back-pressure for 6 cycles with the other port waiting
    #1 lat_cfg = 5'd0; ifu_rsp_ready = 0; ifu_addr = 32'h8000_0010; ifu_req_valid = 1;
    push(0, 0, 32'h8000_0010, 32'h0, 4'h0, 32'h0000_0403, 0, -1);
    push(1, 1, 32'h8000_0200, 32'h1234_5678, 4'hC, 32'h0, 0, 10);
    wait_acc1();
    #1 ifu_req_valid = 0; lsu_wen = 1; lsu_addr = 32'h8000_0200;
    lsu_wdata = 32'h1234_5678; lsu_wmask = 4'hC; lsu_req_valid = 1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!ifu_rsp_valid && n < 50);
    repeat (6) @(posedge clk);
    #1 ifu_rsp_ready = 1;
    wait_acc1(); #1 lsu_req_valid = 0;
    wait_done_n(1);

    // Both valid continuously from reset: LSU, IFU, LSU, IFU, 5 cycles apart
    #1 rst = 1; lat_cfg = 5'd1;
    ifu_addr = 32'h8000_0040; lsu_wen = 0; lsu_addr = 32'h8000_0080;
    lsu_wdata = 32'h0; lsu_wmask = 4'hF;
    ifu_req_valid = 1; lsu_req_valid = 1;
    push(1, 0, 32'h8000_0080, 32'h0, 4'h0, 32'h0000_0493, 1, 0);
    push(0, 0, 32'h8000_0040, 32'h0, 4'h0, 32'h0000_0453, 1, 5);
    push(1, 0, 32'h8000_0080, 32'h0, 4'h0, 32'h0000_0493, 1, 5);
    push(0, 0, 32'h8000_0040, 32'h0, 4'h0, 32'h0000_0453, 1, 5);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    wait_done_n(4);
    #1 ifu_req_valid = 0; lsu_req_valid = 0;

    // Reset while waiting with cnt==5: transaction dropped, LSU wins next tie
    @(posedge clk);
    #1 lat_cfg = 5'd10; ifu_addr = 32'h8000_0030; ifu_req_valid = 1;
    push(0, 0, 32'h8000_0030, 32'h0, 4'h0, 32'h0000_0423, 10, -1);
    wait_acc1(); #1 ifu_req_valid = 0;
    repeat (5) @(posedge clk);
    #1 rst = 1; lat_cfg = 5'd0;
    ifu_addr = 32'h8000_0050; ifu_req_valid = 1;
    lsu_wen = 1; lsu_addr = 32'h8000_0300; lsu_wdata = 32'hA5A5_0001; lsu_wmask = 4'hF;
    lsu_req_valid = 1;
    push(1, 1, 32'h8000_0300, 32'hA5A5_0001, 4'hF, 32'h0, 0, 0);
    push(0, 0, 32'h8000_0050, 32'h0, 4'h0, 32'h0000_0443, 0, 4);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    wait_done_n(2);
    #1 ifu_req_valid = 0; lsu_req_valid = 0;
    repeat (4) @(posedge clk);

    chk("queue_drained", expq.size(), 64'h0);
    chk("no_pending_txn", in_flight, 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1);
  end

endmodule
